// File: rtl/rotate_sequencer_if.sv
// Command/response bundle between the two requesters and the rotate sequencer.
// The requester side drives the job fields; the sequencer returns grants, status and the word.
interface rotate_sequencer_if #(
  parameter int WIDTH  = 100,
  parameter int STEP_W = 7
);
  logic              req_a;
  logic              load_a;
  logic [WIDTH-1:0]  data_a;
  logic [1:0]        dir_a;
  logic [STEP_W-1:0] steps_a;
  logic              req_b;
  logic              load_b;
  logic [WIDTH-1:0]  data_b;
  logic [1:0]        dir_b;
  logic [STEP_W-1:0] steps_b;
  logic              gnt_a;
  logic              gnt_b;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
  logic              done_id;

  modport master (
    output req_a, load_a, data_a, dir_a, steps_a,
    output req_b, load_b, data_b, dir_b, steps_b,
    input  gnt_a, gnt_b, q, busy, done, done_id
  );

  modport slave (
    input  req_a, load_a, data_a, dir_a, steps_a,
    input  req_b, load_b, data_b, dir_b, steps_b,
    output gnt_a, gnt_b, q, busy, done, done_id
  );
endinterface

// File: rtl/rotate_sequencer.sv
// Shared circular shift register: round-robin grants one job at a time, optionally loads
// a word, then rotates it one position per clock and pulses done with the owner id.
module rotate_sequencer #(
  parameter int WIDTH  = 100,
  parameter int STEP_W = 7
) (
  input logic              clk,
  input logic              reset,
  rotate_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  localparam logic [31:0] WIDTH_U = WIDTH[31:0];

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  q;
  logic [STEP_W-1:0] job_cnt;
  logic [1:0]        job_dir;
  logic              owner;
  logic              last_b;
  logic              gnt_a_r;
  logic              gnt_b_r;
  logic              grant_a;
  logic              grant_b;

  // A rotation by WIDTH is the identity, so an oversized count is folded down once;
  // a non-rotating direction never spends any cycles.
  function automatic logic [STEP_W-1:0] eff_count(input logic [STEP_W-1:0] steps,
                                                  input logic [1:0] d);
    logic [31:0] s;
    s = 32'(steps);
    if (d == 2'b00 || d == 2'b11) return '0;
    if (s >= WIDTH_U) return STEP_W'(s - WIDTH_U);
    return steps;
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (bus.req_a && (!bus.req_b || last_b)) grant_a = 1'b1;
        else if (bus.req_b)                      grant_b = 1'b1;
        if (grant_a || grant_b) state_next = ROT;
      end
      ROT:     if (job_cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      q       <= '0;
      job_cnt <= '0;
      job_dir <= 2'b00;
      owner   <= 1'b0;
      last_b  <= 1'b1;
      gnt_a_r <= 1'b0;
      gnt_b_r <= 1'b0;
    end else begin
      state   <= state_next;
      gnt_a_r <= grant_a;
      gnt_b_r <= grant_b;
      if (grant_a || grant_b) begin
        owner   <= grant_b;
        last_b  <= grant_b;
        job_dir <= grant_b ? bus.dir_b : bus.dir_a;
        job_cnt <= grant_b ? eff_count(bus.steps_b, bus.dir_b)
                           : eff_count(bus.steps_a, bus.dir_a);
        if (grant_a && bus.load_a) q <= bus.data_a;
        if (grant_b && bus.load_b) q <= bus.data_b;
      end else if (state == ROT && job_cnt != '0) begin
        job_cnt <= job_cnt - STEP_W'(1);
        q       <= (job_dir == 2'b01) ? rot_right(q) : rot_left(q);
      end
    end
  end

  assign bus.gnt_a   = gnt_a_r;
  assign bus.gnt_b   = gnt_b_r;
  assign bus.q       = q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.done_id = owner;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer: arbitration order, step folding, latency,
// mid-job reset and input isolation, each against hand-computed values.
module tb_rotate_sequencer;
  localparam int W = 100;
  localparam int S = 7;
  typedef logic [W-1:0] word_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   busy_cnt;
  word_t exp_q;

  rotate_sequencer_if #(.WIDTH(W), .STEP_W(S)) bus ();

  rotate_sequencer #(.WIDTH(W), .STEP_W(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit is_b, input bit load, input word_t data,
                       input logic [1:0] dir, input logic [S-1:0] steps);
    int g;
    if (is_b) begin
      bus.load_b = load; bus.data_b = data; bus.dir_b = dir; bus.steps_b = steps; bus.req_b = 1'b1;
    end else begin
      bus.load_a = load; bus.data_a = data; bus.dir_a = dir; bus.steps_a = steps; bus.req_a = 1'b1;
    end
    g = 0;
    do begin
      tick();
      g++;
    end while (!(is_b ? bus.gnt_b : bus.gnt_a) && g < 8);
    check(is_b ? "gnt_b_seen" : "gnt_a_seen", 128'(is_b ? bus.gnt_b : bus.gnt_a), 128'(1));
    if (is_b) bus.req_b = 1'b0;
    else      bus.req_a = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < limit) begin
      tick();
      n++;
      if (bus.done && (bus.gnt_a || bus.gnt_b)) check("gnt_done_overlap", 128'(1), 128'(0));
    end
    check("done_seen", 128'(bus.done), 128'(1));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.req_a = 1'b0; bus.load_a = 1'b0; bus.data_a = '0; bus.dir_a = 2'b00; bus.steps_a = '0;
    bus.req_b = 1'b0; bus.load_b = 1'b0; bus.data_b = '0; bus.dir_b = 2'b00; bus.steps_b = '0;
    tick();
    tick();
    check("rst_q", 128'(bus.q), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_done", 128'(bus.done), 128'(0));
    check("rst_gnt", 128'({bus.gnt_a, bus.gnt_b}), 128'(0));
    check("rst_done_id", 128'(bus.done_id), 128'(0));
    reset = 1'b0;

    // Load 1, rotate right once: bit 99 only, done two cycles after grant.
    issue(1'b0, 1'b1, word_t'(1), 2'b01, S'(1));
    check("t1_busy_at_gnt", 128'(bus.busy), 128'(1));
    check("t1_loaded", 128'(bus.q), 128'(1));
    wait_done(10, cyc);
    check("t1_latency", 128'(cyc), 128'(2));
    check("t1_done_id", 128'(bus.done_id), 128'(0));
    check("t1_q", 128'(bus.q), 128'(word_t'(1) << 99));
    tick();
    check("t1_idle_busy", 128'(bus.busy), 128'(0));
    check("t1_idle_done", 128'(bus.done), 128'(0));

    // Load 0x3, rotate left 5 and watch every step.
    issue(1'b0, 1'b1, word_t'(3), 2'b10, S'(5));
    busy_cnt = bus.busy ? 1 : 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (bus.busy) busy_cnt++;
      check("t2_walk_q", 128'(bus.q), 128'(word_t'(3) << k));
      check("t2_walk_done", 128'(bus.done), 128'(0));
    end
    tick();
    if (bus.busy) busy_cnt++;
    check("t2_done", 128'(bus.done), 128'(1));
    check("t2_q", 128'(bus.q), 128'(word_t'('h60)));
    tick();
    if (bus.busy) busy_cnt++;
    check("t2_busy_cycles", 128'(busy_cnt), 128'(7));

    // Fresh pointer, both requesters held: strict A/B alternation.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.load_a = 1'b0; bus.dir_a = 2'b01; bus.steps_a = '0;
    bus.load_b = 1'b0; bus.dir_b = 2'b01; bus.steps_b = '0;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = 0;
      do begin
        tick();
        g++;
      end while (!(bus.gnt_a || bus.gnt_b) && g < 4);
      check("t3_gnt_a", 128'(bus.gnt_a), 128'(i % 2 == 0));
      check("t3_gnt_b", 128'(bus.gnt_b), 128'(i % 2 == 1));
      check("t3_gnt_no_done", 128'(bus.done), 128'(0));
      tick();
      check("t3_done", 128'(bus.done), 128'(1));
      check("t3_done_id", 128'(bus.done_id), 128'(i % 2));
      check("t3_done_no_gnt", 128'({bus.gnt_a, bus.gnt_b}), 128'(0));
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick();

    // Oversized count folds: 103 right == 3 right.
    issue(1'b0, 1'b1, word_t'(8), 2'b01, S'(103));
    wait_done(10, cyc);
    check("t4_fold_latency", 128'(cyc), 128'(4));
    check("t4_fold_q", 128'(bus.q), 128'(1));
    tick();
    issue(1'b0, 1'b0, word_t'(0), 2'b11, S'(50));
    wait_done(10, cyc);
    check("t4_dir11_latency", 128'(cyc), 128'(1));
    check("t4_dir11_q", 128'(bus.q), 128'(1));
    tick();
    issue(1'b0, 1'b1, word_t'(5), 2'b10, S'(100));
    wait_done(10, cyc);
    check("t4_full_latency", 128'(cyc), 128'(1));
    check("t4_full_q", 128'(bus.q), 128'(5));
    tick();

    // Reset three cycles into a 40-step job abandons it.
    issue(1'b0, 1'b1, word_t'('hF), 2'b10, S'(40));
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_q", 128'(bus.q), 128'(0));
    check("t5_busy", 128'(bus.busy), 128'(0));
    check("t5_done", 128'(bus.done), 128'(0));
    bus.load_a = 1'b0; bus.dir_a = 2'b00; bus.steps_a = '0;
    bus.load_b = 1'b0; bus.dir_b = 2'b00; bus.steps_b = '0;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    tick();
    check("t5_first_a", 128'(bus.gnt_a), 128'(1));
    check("t5_first_not_b", 128'(bus.gnt_b), 128'(0));
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    wait_done(10, cyc);
    check("t5_done_id", 128'(bus.done_id), 128'(0));
    tick();

    // B job isolated from later input changes; A waits for the next IDLE.
    issue(1'b1, 1'b1, (word_t'(1) << 25) | word_t'(1), 2'b01, S'(20));
    for (int k = 0; k < 5; k++) tick();
    bus.data_b = '1; bus.dir_b = 2'b10; bus.steps_b = S'(3); bus.load_b = 1'b1;
    bus.load_a = 1'b0; bus.dir_a = 2'b00; bus.steps_a = '0;
    bus.req_a = 1'b1;
    wait_done(40, cyc);
    check("t6_latency", 128'(cyc + 5), 128'(21));
    check("t6_done_id", 128'(bus.done_id), 128'(1));
    exp_q = (word_t'(1) << 80) | (word_t'(1) << 5);
    check("t6_q", 128'(bus.q), 128'(exp_q));
    check("t6_no_gnt_a_yet", 128'(bus.gnt_a), 128'(0));
    tick();
    check("t6_idle_busy", 128'(bus.busy), 128'(0));
    tick();
    check("t6_gnt_a", 128'(bus.gnt_a), 128'(1));
    check("t6_not_gnt_b", 128'(bus.gnt_b), 128'(0));
    bus.req_a = 1'b0;
    wait_done(10, cyc);
    check("t6_a_done_id", 128'(bus.done_id), 128'(0));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
